// File: rtl/alarm_controller.sv
// Zoned intrusion-alarm sequencer: exit/entry delays, siren timeout, bypass and
// instant masks, latched trip and panic reporting. All outputs are registered.
module alarm_controller #(
  parameter int NUM_ZONES   = 3,
  parameter int CNT_W       = 8,
  parameter int EXIT_DELAY  = 16,
  parameter int ENTRY_DELAY = 8,
  parameter int SIREN_TIME  = 32
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 PANIC,
  input  logic                 ENABLE,
  input  logic                 CLEAR,
  input  logic [NUM_ZONES-1:0] ZONE_CLOSED,
  input  logic [NUM_ZONES-1:0] ZONE_BYPASS,
  input  logic [NUM_ZONES-1:0] ZONE_INSTANT,
  output logic                 ALARM,
  output logic                 ARMED,
  output logic [2:0]           STATE,
  output logic [NUM_ZONES-1:0] TRIPPED,
  output logic                 PANIC_FLAG,
  output logic [CNT_W-1:0]     TIMER
);

  localparam logic [2:0] DISARMED = 3'd0;
  localparam logic [2:0] EXIT     = 3'd1;
  localparam logic [2:0] ARMED_S  = 3'd2;
  localparam logic [2:0] ENTRY    = 3'd3;
  localparam logic [2:0] ALARM_S  = 3'd4;
  localparam logic [2:0] SILENCED = 3'd5;

  localparam longint TMAX = (64'sd1 <<< CNT_W) - 64'sd1;

  if (NUM_ZONES < 1 ||
      EXIT_DELAY  < 1 || longint'(EXIT_DELAY)  > TMAX ||
      ENTRY_DELAY < 1 || longint'(ENTRY_DELAY) > TMAX ||
      SIREN_TIME  < 1 || longint'(SIREN_TIME)  > TMAX) begin : g_bad_param
    $error("alarm_controller: delay parameter out of range for CNT_W");
  end

  localparam logic [CNT_W-1:0] EXIT_LD  = CNT_W'(EXIT_DELAY - 1);
  localparam logic [CNT_W-1:0] ENTRY_LD = CNT_W'(ENTRY_DELAY - 1);
  localparam logic [CNT_W-1:0] SIREN_LD = CNT_W'(SIREN_TIME - 1);

  logic [2:0]           state_q, state_d;
  logic [CNT_W-1:0]     timer_q, timer_d;
  logic [NUM_ZONES-1:0] trip_q, trip_d;
  logic                 pflag_q, pflag_d;
  logic                 alarm_q, armed_q;
  logic [NUM_ZONES-1:0] act;
  logic                 inst_trip, any_trip, new_trip, tmr_zero;

  assign act       = ~ZONE_CLOSED & ~ZONE_BYPASS;
  assign inst_trip = |(act & ZONE_INSTANT);
  assign any_trip  = |act;
  assign new_trip  = |(act & ~trip_q);
  assign tmr_zero  = (timer_q == '0);

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    trip_d  = trip_q;
    pflag_d = pflag_q;
    if (state_q inside {ARMED_S, ENTRY, ALARM_S, SILENCED}) trip_d = trip_q | act;
    if (PANIC) begin
      state_d = ALARM_S;
      timer_d = SIREN_LD;
      pflag_d = 1'b1;
    end else begin
      case (state_q)
        DISARMED: if (ENABLE) begin state_d = EXIT; timer_d = EXIT_LD; end
        EXIT: begin
          if (!ENABLE)       state_d = DISARMED;
          else if (tmr_zero) state_d = ARMED_S;
          else               timer_d = timer_q - CNT_W'(1);
        end
        ARMED_S: begin
          if (!ENABLE)        state_d = DISARMED;
          else if (inst_trip) begin state_d = ALARM_S; timer_d = SIREN_LD; end
          else if (any_trip)  begin state_d = ENTRY;   timer_d = ENTRY_LD; end
        end
        ENTRY: begin
          // Only disarm cancels the grace period; re-closing the zone does not.
          if (!ENABLE)                    state_d = DISARMED;
          else if (inst_trip || tmr_zero) begin state_d = ALARM_S; timer_d = SIREN_LD; end
          else                            timer_d = timer_q - CNT_W'(1);
        end
        ALARM_S: begin
          if (CLEAR)         state_d = DISARMED;
          else if (tmr_zero) state_d = SILENCED;
          else               timer_d = timer_q - CNT_W'(1);
        end
        SILENCED: begin
          if (CLEAR)         state_d = DISARMED;
          else if (new_trip) begin state_d = ALARM_S; timer_d = SIREN_LD; end
        end
        default: state_d = DISARMED;
      endcase
    end
    if (state_d == DISARMED) begin
      timer_d = '0;
      trip_d  = '0;
      pflag_d = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= DISARMED;
      timer_q <= '0;
      trip_q  <= '0;
      pflag_q <= 1'b0;
      alarm_q <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      trip_q  <= trip_d;
      pflag_q <= pflag_d;
      alarm_q <= (state_d == ALARM_S);
      armed_q <= (state_d == ARMED_S) || (state_d == ENTRY);
    end
  end

  assign ALARM      = alarm_q;
  assign ARMED      = armed_q;
  assign STATE      = state_q;
  assign TRIPPED    = trip_q;
  assign PANIC_FLAG = pflag_q;
  assign TIMER      = timer_q;

endmodule

// File: tb/tb_alarm_controller.sv
// Bench for alarm_controller: per-cycle reference model feeding a scoreboard
// queue, directed scenarios from the test plan plus a random soak.
module tb_alarm_controller;
  localparam int NZ = 3, CW = 8, EXD = 4, END = 3, SRT = 5;

  logic          clk = 1'b0;
  logic          rst_n, panic, enable, clear;
  logic [NZ-1:0] zc, zb, zi;
  logic          alarm, armed, pflag;
  logic [2:0]    state;
  logic [NZ-1:0] trip;
  logic [CW-1:0] timer;

  alarm_controller #(.NUM_ZONES(NZ), .CNT_W(CW), .EXIT_DELAY(EXD),
                     .ENTRY_DELAY(END), .SIREN_TIME(SRT)) dut (
    .CLK(clk), .RST_N(rst_n), .PANIC(panic), .ENABLE(enable), .CLEAR(clear),
    .ZONE_CLOSED(zc), .ZONE_BYPASS(zb), .ZONE_INSTANT(zi),
    .ALARM(alarm), .ARMED(armed), .STATE(state), .TRIPPED(trip),
    .PANIC_FLAG(pflag), .TIMER(timer));

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]    st;
    logic          al, ar, pf;
    logic [NZ-1:0] tr;
    logic [CW-1:0] tm;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0, n_pass = 0;

  // reference state
  int            m_st = 0, m_tm = 0;
  logic [NZ-1:0] m_tr = '0;
  logic          m_pf = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // Reference: state names 0 DIS, 1 EXIT, 2 ARMED, 3 ENTRY, 4 ALARM, 5 SILENCED
  task automatic model_step();
    logic [NZ-1:0] a;
    int ns, nt;
    logic [NZ-1:0] ntr;
    logic npf;
    a = ~zc & ~zb;
    ns = m_st; nt = m_tm; ntr = m_tr; npf = m_pf;
    if (m_st >= 2 && m_st <= 5) ntr = m_tr | a;
    if (!rst_n) begin
      ns = 0;
    end else if (panic) begin
      ns = 4; nt = SRT - 1; npf = 1'b1;
    end else if (clear && (m_st == 4 || m_st == 5)) begin
      ns = 0;
    end else if (!enable && (m_st >= 1 && m_st <= 3)) begin
      ns = 0;
    end else if ((m_st == 2 || m_st == 3) && (a & zi) != 0) begin
      ns = 4; nt = SRT - 1;
    end else if (m_st == 2 && a != 0) begin
      ns = 3; nt = END - 1;
    end else if (m_st == 5 && (a & ~m_tr) != 0) begin
      ns = 4; nt = SRT - 1;
    end else if (m_st == 0) begin
      if (enable) begin ns = 1; nt = EXD - 1; end
    end else if (m_st == 1 || m_st == 3 || m_st == 4) begin
      if (m_tm == 0) ns = (m_st == 1) ? 2 : (m_st == 3) ? 4 : 5;
      if (m_tm == 0 && m_st == 3) nt = SRT - 1;
      else if (m_tm > 0) nt = m_tm - 1;
    end
    if (ns == 0) begin nt = 0; ntr = '0; npf = 1'b0; end
    m_st = ns; m_tm = nt; m_tr = ntr; m_pf = npf;
  endtask

  task automatic step(input int n = 1);
    exp_t e, g;
    for (int k = 0; k < n; k++) begin
      model_step();
      e.st = 3'(m_st); e.tm = CW'(m_tm); e.tr = m_tr; e.pf = m_pf;
      e.al = (m_st == 4); e.ar = (m_st == 2 || m_st == 3);
      q.push_back(e);
      @(posedge clk); #1;
      g = q.pop_front();
      chk("state", 32'(state), 32'(g.st));
      chk("timer", 32'(timer), 32'(g.tm));
      chk("tripped", 32'(trip), 32'(g.tr));
      chk("panic_flag", 32'(pflag), 32'(g.pf));
      chk("alarm", 32'(alarm), 32'(g.al));
      chk("armed", 32'(armed), 32'(g.ar));
    end
  endtask

  task automatic arm();  // from DISARMED, doors closed: land in quiet ARMED_S
    enable = 1'b1; step(EXD + 1);
  endtask

  initial begin
    rst_n = 1'b0; panic = 1'b0; enable = 1'b0; clear = 1'b0;
    zc = 3'b111; zb = 3'b000; zi = 3'b001;
    #2;
    // reset then arm, door open during EXIT
    step(2);
    chk("rst_state", 32'(state), 0); chk("rst_timer", 32'(timer), 0);
    chk("rst_alarm", 32'(alarm), 0);
    rst_n = 1'b1; enable = 1'b1; zc = 3'b101;
    step(1); chk("exit_enter", 32'(state), 1); chk("exit_t3", 32'(timer), 3);
    step(2); chk("exit_t1", 32'(timer), 1); chk("exit_door_ign", 32'(trip), 0);
    zc = 3'b111;
    step(1); chk("exit_t0", 32'(timer), 0); chk("exit_not_armed", 32'(armed), 0);
    step(1); chk("armed_at4", 32'(armed), 1); chk("armed_state", 32'(state), 2);
    step(2); chk("quiet_armed", 32'(trip), 0);

    // entry delay on door
    zc = 3'b101; step(1); chk("entry_t2", 32'(timer), 2); chk("entry_st", 32'(state), 3);
    zc = 3'b111; step(2); chk("entry_t0", 32'(timer), 0); chk("entry_noalarm", 32'(alarm), 0);
    step(1); chk("entry_alarm", 32'(alarm), 1); chk("entry_trip", 32'(trip), 3'b010);
    // clear with ENABLE held: DISARMED then EXIT
    clear = 1'b1; step(1); chk("clr_dis", 32'(state), 0);
    clear = 1'b0; step(1); chk("clr_reexit", 32'(state), 1);
    step(EXD); chk("rearmed", 32'(state), 2);
    // entry variant: disarm during ENTRY
    zc = 3'b101; step(1); zc = 3'b111;
    enable = 1'b0; step(1); chk("entry_disarm", 32'(state), 0);
    chk("entry_disarm_trip", 32'(trip), 0); chk("entry_disarm_al", 32'(alarm), 0);

    // instant window, siren timeout, garage re-trip
    arm();
    zc = 3'b110; step(1); chk("inst_alarm", 32'(alarm), 1); chk("inst_t4", 32'(timer), 4);
    zc = 3'b111; step(4); chk("siren_last", 32'(alarm), 1);
    step(1); chk("silenced", 32'(state), 5); chk("silenced_al", 32'(alarm), 0);
    step(1); chk("silenced_hold", 32'(timer), 0);
    zc = 3'b011; step(1); chk("garage_alarm", 32'(state), 4);
    chk("garage_trip", 32'(trip), 3'b101);
    zc = 3'b111; clear = 1'b1; enable = 1'b0; step(1); clear = 1'b0;

    // bypass garage
    zb = 3'b100; arm();
    zc = 3'b011; step(3); chk("bypass_st", 32'(state), 2); chk("bypass_trip", 32'(trip), 0);
    zc = 3'b111; zb = 3'b000; enable = 1'b0; step(1);

    // panic and clear
    panic = 1'b1; step(1); chk("panic_al", 32'(alarm), 1); chk("panic_pf", 32'(pflag), 1);
    panic = 1'b0; step(1);
    clear = 1'b1; step(1); chk("panic_clr", 32'(state), 0); chk("panic_clr_pf", 32'(pflag), 0);
    panic = 1'b1; step(1); chk("panic_wins", 32'(state), 4); chk("panic_wins_t", 32'(timer), SRT - 1);
    panic = 1'b0; step(1); clear = 1'b0;

    // reset mid-ENTRY at TIMER=1
    arm(); zc = 3'b101; step(1); zc = 3'b111; step(1);
    chk("pre_rst_t1", 32'(timer), 1);
    rst_n = 1'b0; step(1); chk("mid_rst_st", 32'(state), 0); chk("mid_rst_al", 32'(alarm), 0);
    rst_n = 1'b1; enable = 1'b0; step(1);

    // random soak against the reference
    for (int i = 0; i < 400; i++) begin
      rst_n  = ($urandom_range(0, 99) != 0);
      panic  = ($urandom_range(0, 49) == 0);
      clear  = ($urandom_range(0, 19) == 0);
      enable = ($urandom_range(0, 15) != 0);
      zc     = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b111;
      zb     = ($urandom_range(0, 7) == 0) ? 3'($urandom) : 3'b000;
      zi     = ($urandom_range(0, 15) == 0) ? 3'($urandom) : 3'b001;
      step(1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/alarm_controller.md
Name: alarm_controller

Overview:
- Sequential, parametrised successor to the combinational `alarm` block.
- Generalises the fixed WINDOW/DOOR/GARAGE inputs to NUM_ZONES sensor zones.
- Replaces the EXITING input with internal exit and entry delay timers, and adds a siren timeout, per-zone bypass/instant masks and latched trip reporting.
- Sits between the sensor input synchronisers and the siren driver / status display.

Parameters:
- NUM_ZONES, 3, number of sensor zones (>=1).
- CNT_W, 8, timer width in bits.
- EXIT_DELAY, 16, cycles from arming request to ARMED (1..2^CNT_W-1).
- ENTRY_DELAY, 8, cycles of grace after a delayed-zone trip before ALARM (1..2^CNT_W-1).
- SIREN_TIME, 32, cycles ALARM stays high before auto-silencing (1..2^CNT_W-1).

Ports:
- CLK  in  1  system clock; all state updates on its rising edge.
- RST_N  in  1  synchronous active-low reset, sampled on rising CLK.
- PANIC  in  1  level; 1 forces the alarm state from any state.
- ENABLE  in  1  level; 1 = arm request, 0 = disarm request.
- CLEAR  in  1  level; 1 acknowledges ALARM/SILENCED and returns to DISARMED.
- ZONE_CLOSED  in  NUM_ZONES  per zone: 1 = secure, 0 = open.
- ZONE_BYPASS  in  NUM_ZONES  per zone: 1 = zone ignored entirely.
- ZONE_INSTANT  in  NUM_ZONES  per zone: 1 = trip goes straight to ALARM; 0 = entry delay applies.
- ALARM  out  1  siren drive.
- ARMED  out  1  system armed.
- STATE  out  3  current state encoding.
- TRIPPED  out  NUM_ZONES  latched zones that opened while protection was active.
- PANIC_FLAG  out  1  latched: the current alarm was raised by PANIC.
- TIMER  out  CNT_W  remaining count of the active delay.

Behaviour:
- Reset (RST_N=0 at a rising edge, from any state, including mid-delay):
  - STATE=DISARMED.
  - ALARM=0, ARMED=0, TRIPPED=0, PANIC_FLAG=0, TIMER=0.
- All outputs are registered. There is no combinational input-to-output path.
- State encoding:
  - DISARMED=0, EXIT=1, ARMED_S=2, ENTRY=3, ALARM_S=4, SILENCED=5.
  - Codes 6 and 7 are illegal and recover to DISARMED on the next cycle.
- Active zone definition: act[i] = ~ZONE_CLOSED[i] & ~ZONE_BYPASS[i].
- Priority, evaluated each cycle from highest to lowest:
  - reset
  - PANIC
  - CLEAR (ALARM_S/SILENCED only)
  - ENABLE=0 (EXIT/ARMED_S/ENTRY only)
  - instant trip
  - delayed trip
  - timer expiry
- PANIC=1 in any state:
  - Next state is ALARM_S, TIMER=SIREN_TIME-1, PANIC_FLAG=1.
  - Held PANIC keeps reloading TIMER.
- DISARMED:
  - ENABLE=1 -> EXIT with TIMER=EXIT_DELAY-1.
  - Zones are ignored.
- EXIT:
  - Zones are ignored.
  - ENABLE=0 -> DISARMED.
  - TIMER=0 -> ARMED_S; otherwise TIMER decrements.
  - ARMED asserts exactly EXIT_DELAY cycles after the first cycle in EXIT.
- ARMED_S:
  - ENABLE=0 -> DISARMED.
  - Any act[i] & ZONE_INSTANT[i] -> ALARM_S with TIMER=SIREN_TIME-1.
  - Else any act[i] -> ENTRY with TIMER=ENTRY_DELAY-1.
- ENTRY:
  - ENABLE=0 -> DISARMED. Disarm wins over expiry in the same cycle.
  - Instant trip -> ALARM_S.
  - TIMER=0 -> ALARM_S; otherwise TIMER decrements.
  - Closing the zone does not cancel the entry delay.
- ALARM_S:
  - TIMER decrements; at 0 -> SILENCED.
  - ENABLE has no effect; only CLEAR exits.
- SILENCED:
  - ALARM=0; TIMER holds 0.
  - An active zone with TRIPPED[i]=0 opening -> ALARM_S with TIMER=SIREN_TIME-1.
  - CLEAR -> DISARMED.
- CLEAR with PANIC=0 in ALARM_S/SILENCED -> DISARMED. If ENABLE is still 1, the block proceeds to EXIT on the following cycle.
- TRIPPED:
  - TRIPPED[i] sets when act[i]=1 in ARMED_S, ENTRY, ALARM_S or SILENCED.
  - All bits clear on entry to DISARMED.
- PANIC_FLAG clears on entry to DISARMED.
- ALARM=1 iff STATE=ALARM_S.
- ARMED=1 iff STATE is ARMED_S or ENTRY.
- TIMER=0 in DISARMED and ARMED_S.
- Timer arithmetic: unsigned, never wraps below 0. Parameter values must fit in CNT_W; exceeding it is an elaboration error.

Test Plan:
Common settings: NUM_ZONES=3 (bit0=WINDOW, bit1=DOOR, bit2=GARAGE), EXIT_DELAY=4, ENTRY_DELAY=3, SIREN_TIME=5, ZONE_INSTANT=3'b001.
- Reset then arm:
  - Stimulus: RST_N low 2 cycles, then ENABLE=1 with ZONE_CLOSED=3'b101 (door open) during EXIT.
  - Response: STATE 0->1; TIMER 3,2,1,0; ARMED=1 four cycles after EXIT entry; door ignored during EXIT.
  - Note: with the door still open, ARMED_S trips it on the next cycle, so close the door before EXIT ends when checking a quiet ARMED_S.
- Entry delay:
  - Stimulus: armed, door (bit1) opens for 1 cycle.
  - Response: ENTRY with TIMER 2,1,0, then ALARM=1, TRIPPED=3'b010.
  - Variant: ENABLE=0 during ENTRY -> DISARMED, ALARM never asserts, TRIPPED=0.
- Instant zone and siren timeout:
  - Stimulus: armed, window (bit0) opens.
  - Response: ALARM=1 next cycle for 5 cycles, then SILENCED (STATE=5), ALARM=0.
  - Follow-up: garage opens -> ALARM_S again, TRIPPED=3'b101.
- Bypass:
  - Stimulus: ZONE_BYPASS=3'b100, armed, garage open.
  - Response: stays ARMED_S, TRIPPED=0.
- Panic and clear:
  - Stimulus: DISARMED, PANIC=1 for 1 cycle.
  - Response: ALARM=1, PANIC_FLAG=1. CLEAR=1 during ALARM_S -> DISARMED, all outputs at reset values.
  - Stimulus: PANIC and CLEAR together.
  - Response: PANIC wins.
- Reset mid-operation:
  - Stimulus: RST_N=0 during ENTRY with TIMER=1.
  - Response: next cycle all outputs at reset values; no ALARM pulse.
